// File: rtl/synth_pkg.sv
// Shared synth voice constants: accumulator width, top octave, semitone increment table, converter states.
// Pure declarations, no logic, no latency.
// No handshakes here; the users of these constants own their flow control.
package synth_pkg;

    localparam int ACC_W      = 24;
    localparam int TOP_OCTAVE = 10;

    // 24-bit phase increments for notes 120..131 at 48 kHz, rounded
    localparam logic [ACC_W-1:0] SEMI_INC [12] = '{
        24'd2926232, 24'd3100235, 24'd3284585, 24'd3479896,
        24'd3686822, 24'd3906052, 24'd4138318, 24'd4384395,
        24'd4645104, 24'd4921317, 24'd5213953, 24'd5523991
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        APPLY = 2'd2
    } conv_state_e;

endpackage

// File: rtl/phase_generator_if.sv
// Note event handshake plus phase/gate outputs of one voice oscillator.
// Wires only, no latency.
// note_valid is held by the source until note_ready; the phase outputs cannot be stalled.
interface phase_generator_if #(
    parameter int PHASE_W = 10
);
    logic               note_valid;
    logic               note_ready;
    logic               note_on;
    logic [6:0]         note_num;
    logic [PHASE_W-1:0] phase;
    logic               phase_valid;
    logic               gate;

    modport master (
        output note_valid, note_on, note_num,
        input  note_ready, phase, phase_valid, gate
    );

    modport slave (
        input  note_valid, note_on, note_num,
        output note_ready, phase, phase_valid, gate
    );
endinterface

// File: rtl/note_to_inc.sv
// Note number to phase increment: repeated subtract-12 octave divider, then table lookup and shift.
// Accept edge k, done_vld high in the cycle before edge k + oct + 2.
// req_rdy is low from the accept edge until the APPLY cycle has completed.
module note_to_inc
    import synth_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [6:0]       req_num,
    output logic             done_vld,
    output logic [ACC_W-1:0] inc_dat
);

    localparam logic [3:0] TOP_OCT4 = 4'(TOP_OCTAVE);

    conv_state_e state_q, state_d;
    logic [6:0]  rem_q, rem_d;
    logic [3:0]  oct_q, oct_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            oct_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            oct_q   <= oct_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        oct_d   = oct_q;
        unique case (state_q)
            IDLE: begin
                if (req_vld) begin
                    rem_d   = req_num;
                    oct_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (rem_q >= 7'd12) begin
                    rem_d = rem_q - 7'd12;
                    oct_d = oct_q + 4'd1;
                end else begin
                    state_d = APPLY;
                end
            end
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_rdy  = (state_q == IDLE);
    assign done_vld = (state_q == APPLY);
    // In APPLY rem_q < 12, so its low nibble is a valid table index
    assign inc_dat  = SEMI_INC[rem_q[3:0]] >> (TOP_OCT4 - oct_q);

endmodule

// File: rtl/phase_generator.sv
// Per-voice NCO: note events -> 24-bit accumulator -> PHASE_W phase; optional portamento via PHASE_GENERATOR_GLIDE_EN.
// Note-on takes oct + 2 cycles to reach inc_cur/gate; phase/phase_valid appear the cycle after sample_tick.
// note_ready drops while a note-on converts; sample_tick is never stalled.
module phase_generator
    import synth_pkg::*;
#(
    parameter int PHASE_W     = 10,
    parameter bit RETRIGGER   = 1'b1,
    parameter int GLIDE_SHIFT = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_tick,
    phase_generator_if.slave nif
);

    if (PHASE_W < 1 || PHASE_W > ACC_W || GLIDE_SHIFT < 0 || GLIDE_SHIFT >= ACC_W) begin : g_cfg_chk
        $error("phase_generator: unsupported PHASE_W or GLIDE_SHIFT");
    end

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_cur_q, inc_cur_d;
    logic             gate_q, gate_d;
    logic             phase_valid_q, phase_valid_d;
    logic [6:0]       cur_note_q, cur_note_d;

    logic             conv_rdy;
    logic             done_vld;
    logic [ACC_W-1:0] inc_dat;
    logic             on_acc;
    logic             off_acc;

    assign on_acc  = nif.note_valid &&  nif.note_on && conv_rdy;
    assign off_acc = nif.note_valid && !nif.note_on && conv_rdy;

    note_to_inc u_note_to_inc (
        .clk      (clk),
        .reset    (reset),
        .req_vld  (nif.note_valid && nif.note_on),
        .req_rdy  (conv_rdy),
        .req_num  (nif.note_num),
        .done_vld (done_vld),
        .inc_dat  (inc_dat)
    );

`ifdef PHASE_GENERATOR_GLIDE_EN
    logic [ACC_W-1:0] inc_target_q, inc_target_d;
    logic             slew_down;
    logic [ACC_W-1:0] slew_mag;
    logic [ACC_W-1:0] slew_step;
    logic [ACC_W-1:0] inc_slewed;

    always_comb begin
        slew_down = (inc_target_q < inc_cur_q);
        slew_mag  = slew_down ? (inc_cur_q - inc_target_q) : (inc_target_q - inc_cur_q);
        slew_step = slew_mag >> GLIDE_SHIFT;
        // Keep creeping by 1 so the increment lands exactly on the target
        if (slew_step == '0 && slew_mag != '0) begin
            slew_step = ACC_W'(1);
        end
        inc_slewed = slew_down ? (inc_cur_q - slew_step) : (inc_cur_q + slew_step);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inc_target_q <= '0;
        end else begin
            inc_target_q <= inc_target_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q         <= '0;
            inc_cur_q     <= '0;
            gate_q        <= 1'b0;
            phase_valid_q <= 1'b0;
            cur_note_q    <= '0;
        end else begin
            acc_q         <= acc_d;
            inc_cur_q     <= inc_cur_d;
            gate_q        <= gate_d;
            phase_valid_q <= phase_valid_d;
            cur_note_q    <= cur_note_d;
        end
    end

    always_comb begin
        acc_d         = acc_q;
        inc_cur_d     = inc_cur_q;
        gate_d        = gate_q;
        cur_note_d    = cur_note_q;
        phase_valid_d = sample_tick;
`ifdef PHASE_GENERATOR_GLIDE_EN
        inc_target_d  = inc_target_q;
`endif

        // Accumulate with the increment in force before this edge
        if (sample_tick) begin
            acc_d = acc_q + inc_cur_q;
`ifdef PHASE_GENERATOR_GLIDE_EN
            inc_cur_d = inc_slewed;
`endif
        end

        if (on_acc) begin
            cur_note_d = nif.note_num;
        end

        // Increment stays put on note-off so the release tail keeps sounding
        if (off_acc && nif.note_num == cur_note_q) begin
            gate_d = 1'b0;
        end

        if (done_vld) begin
            gate_d = 1'b1;
`ifdef PHASE_GENERATOR_GLIDE_EN
            inc_target_d = inc_dat;
`else
            inc_cur_d = inc_dat;
`endif
            if (RETRIGGER) begin
                acc_d = '0;
            end
        end
    end

    assign nif.note_ready  = conv_rdy;
    assign nif.phase       = acc_q[ACC_W-1 -: PHASE_W];
    assign nif.phase_valid = phase_valid_q;
    assign nif.gate        = gate_q;

endmodule

// File: tb/tb_phase_generator.sv
// Bench for phase_generator: directed note events with a queue of expected phases drained by a monitor.
// A second instance with RETRIGGER = 0 shares the stimulus for the tick/APPLY collision case.
module tb_phase_generator;

    localparam int PW = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sample_tick = 1'b0;

    always #5 clk = ~clk;

    phase_generator_if #(.PHASE_W(PW)) pif ();
    phase_generator_if #(.PHASE_W(PW)) nif ();

    assign nif.note_valid = pif.note_valid;
    assign nif.note_on    = pif.note_on;
    assign nif.note_num   = pif.note_num;

    phase_generator #(.PHASE_W(PW), .RETRIGGER(1'b1), .GLIDE_SHIFT(6)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .nif(pif)
    );

    phase_generator #(.PHASE_W(PW), .RETRIGGER(1'b0), .GLIDE_SHIFT(6)) dut_nr (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .nif(nif)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [PW-1:0] exp_q [$];
    logic [23:0]   m_acc = '0;
    int            m_inc = 0;
    int            m_tgt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: accumulate with the pre-slew increment, then slew toward the target
    task automatic tick();
        int diff;
        int st;
        @(negedge clk);
        sample_tick = 1'b1;
        m_acc = m_acc + 24'(m_inc);
`ifdef PHASE_GENERATOR_GLIDE_EN
        diff = m_tgt - m_inc;
        st = (diff < 0 ? -diff : diff) >>> 6;
        if (st == 0 && diff != 0) st = 1;
        m_inc = (diff < 0) ? m_inc - st : m_inc + st;
`else
        diff = 0;
        st = diff;
`endif
        exp_q.push_back(m_acc[23 -: PW]);
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic send(input bit on, input logic [6:0] num, input int exp_low, input int exp_inc);
        int low;
        @(negedge clk);
        pif.note_valid = 1'b1;
        pif.note_on    = on;
        pif.note_num   = num;
        @(negedge clk);
        pif.note_valid = 1'b0;
        low = 0;
        while (!pif.note_ready && low < 50) begin
            low++;
            @(negedge clk);
        end
        check($sformatf("ready_low_n%0d", num), low, exp_low);
        if (on) begin
            m_acc = '0;
`ifdef PHASE_GENERATOR_GLIDE_EN
            m_tgt = exp_inc;
`else
            m_inc = exp_inc;
            check($sformatf("inc_cur_n%0d", num), dut.inc_cur_q, exp_inc);
`endif
            check($sformatf("gate_on_n%0d", num), pif.gate, 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", pif.note_ready, 1);
        check("rst_gate", pif.gate, 0);
        check("rst_phase", pif.phase, 0);
        check("rst_phase_valid", pif.phase_valid, 0);
        check("rst_inc_cur", dut.inc_cur_q, 0);
        check("rst_acc", dut.acc_q, 0);
        check("rst_sb_empty", exp_q.size(), 0);
        m_acc = '0;
        m_inc = 0;
        m_tgt = 0;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset && pif.phase_valid) begin
            check("sb_has_entry", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("phase", pif.phase, exp_q.pop_front());
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        pif.note_valid = 1'b0;
        pif.note_on    = 1'b0;
        pif.note_num   = '0;
        do_reset();

`ifdef PHASE_GENERATOR_GLIDE_EN
        send(1'b1, 7'd69, 7, 153791);
        check("glide_first_from_0", dut.inc_cur_q, 0);
        for (int i = 0; i < 1500 && dut.inc_cur_q != 24'd153791; i++) tick();
        check("glide_conv_69", dut.inc_cur_q, 153791);
        send(1'b1, 7'd81, 8, 307582);
        tick();
        check("glide_first_step", dut.inc_cur_q, 156193);
        for (int i = 0; i < 1500 && dut.inc_cur_q != 24'd307582; i++) tick();
        check("glide_conv_81", dut.inc_cur_q, 307582);
        repeat (2) tick();
        check("glide_hold_81", dut.inc_cur_q, 307582);
`else
        // Tick lands on the APPLY edge of note 0, following note 69
        send(1'b1, 7'd69, 7, 153791);
        @(negedge clk);
        pif.note_valid = 1'b1;
        pif.note_on    = 1'b1;
        pif.note_num   = 7'd0;
        @(negedge clk);
        pif.note_valid = 1'b0;
        @(negedge clk);
        sample_tick = 1'b1;
        m_acc = '0;
        m_inc = 2857;
        exp_q.push_back('0);
        @(negedge clk);
        sample_tick = 1'b0;
        check("coll_retrig_acc", dut.acc_q, 0);
        check("coll_noretrig_acc", dut_nr.acc_q, 153791);
        check("coll_inc_new", dut.inc_cur_q, 2857);
        check("coll_noretrig_inc", dut_nr.inc_cur_q, 2857);
        repeat (2) tick();

        send(1'b1, 7'd127, 12, 4384395);
        repeat (2) tick();
        send(1'b1, 7'd0, 2, 2857);
        repeat (2) tick();

        send(1'b1, 7'd69, 7, 153791);
        repeat (109) tick();
        check("phase_109", pif.phase, 1023);
        tick();
        check("acc_110_wrap", dut.acc_q, 139794);
        check("phase_110_wrap", pif.phase, 8);

        send(1'b0, 7'd70, 0, 0);
        check("off_other_gate", pif.gate, 1);
        repeat (2) tick();

        // Reset part-way through converting note 100
        @(negedge clk);
        pif.note_valid = 1'b1;
        pif.note_on    = 1'b1;
        pif.note_num   = 7'd100;
        @(negedge clk);
        pif.note_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("conv_busy", pif.note_ready, 0);
        do_reset();

        send(1'b1, 7'd69, 7, 153791);
        repeat (3) tick();
        send(1'b0, 7'd69, 0, 0);
        check("off_match_gate", pif.gate, 0);
        check("off_inc_kept", dut.inc_cur_q, 153791);
        repeat (3) tick();
        check("off_acc_runs", dut.acc_q, 6 * 153791);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/phase_generator.md
# phase_generator

Numerically controlled oscillator that turns MIDI note-on/note-off events into the 10-bit `phase` stream consumed by the wavetable block. One instance per voice. It converts a note number to a phase increment with a small multi-cycle state machine, then advances a 24-bit accumulator once per audio `sample_tick`. It also provides the gate signal used by the downstream envelope.

## Interface
- `PHASE_W`, 10: width of the `phase` output; the top bits of the accumulator; must be ≤ 24.
- `RETRIGGER`, 1: 1 = a note-on clears the accumulator to 0; 0 = phase continues.
- `GLIDE_SHIFT`, 6: glide slew divisor exponent; used only with `GLIDE_EN`.
- `clk` in 1: system clock.
- `reset` in 1: reset; asynchronous, active-low.
- `sample_tick` in 1: one-cycle pulse at the audio rate (48 kHz).
- `note_valid` in 1: event request.
- `note_ready` out 1: event accepted when `note_valid && note_ready` at a clock edge.
- `note_on` in 1: 1 = note-on, 0 = note-off.
- `note_num` in 7: MIDI note 0..127.
- `phase` out PHASE_W: `acc[23 -: PHASE_W]`.
- `phase_valid` out 1: one-cycle pulse on the cycle after each `sample_tick`.
- `gate` out 1: a note is currently held.

## Operation
- State machine `IDLE`, `CONV`, `APPLY`. `note_ready = (state == IDLE)`.
- **IDLE, note-on accepted:**
  - latch `rem = note_num`, `oct = 0`, `cur_note = note_num`.
  - go to `CONV`.
- **IDLE, note-off accepted:**
  - stay in `IDLE`.
  - if `note_num == cur_note`, `gate <= 0` at that edge; otherwise no effect.
  - the increment is retained, so phase keeps running for the release tail.
- **CONV:** each cycle, if `rem ≥ 12` then `rem -= 12`, `oct += 1`; else go to `APPLY`.
- **APPLY:**
  - `inc_target = SEMI_INC[rem] >> (10 − oct)`.
  - `gate <= 1`.
  - if `RETRIGGER`, `acc <= 0`.
  - return to `IDLE`.
- Without glide, `inc_cur <= inc_target` in `APPLY`.
- **Accumulator:** on `sample_tick`, `acc <= acc + inc_cur`, modulo 2^24; wrap-around is silent.
- `SEMI_INC[s]` holds the 24-bit increments for notes 120+s at Fs = 48 kHz, rounded. Example: entry 9 = 4921317.
- `note_valid` during `CONV`/`APPLY` is not accepted; the source holds it.
- A note-on for the note already gated is processed normally (retrigger per `RETRIGGER`).

## Timing
- Reset values: `acc = 0`, `inc_cur = inc_target = 0`, `phase = 0`, `phase_valid = 0`, `gate = 0`, `cur_note = 0`, state `IDLE`, so `note_ready = 1`.
- **Note-on latency:** accept edge k, then `inc_cur`/`gate` update at edge k + oct + 2. `note_ready` is high again from that edge.
- **Phase latency:** the accumulator updates on the edge where `sample_tick` = 1. `phase` reflects the new value and `phase_valid` = 1 for the following cycle.
- `sample_tick` coincident with `APPLY`:
  - if `RETRIGGER`, the clear wins (`acc = 0`).
  - otherwise the accumulate uses the old `inc_cur`.
  - `phase_valid` still pulses.
- Reset asserted mid-`CONV` aborts the conversion immediately. The event is lost and all outputs take their reset values.

## Configuration
- **`PHASE_GENERATOR_GLIDE_EN` defined (portamento):**
  - `APPLY` sets only `inc_target`.
  - on each `sample_tick`, `inc_cur` moves toward `inc_target` by `|diff| >> GLIDE_SHIFT`, with a minimum step of 1 while `diff ≠ 0`.
  - the accumulate on that tick uses the pre-slew `inc_cur`.
  - the first note after reset also glides from 0.
- **Undefined:** `inc_cur` jumps to the target in `APPLY`, and `GLIDE_SHIFT` is ignored.

## Structure
- **Shared package `synth_pkg`:**
  - `ACC_W = 24`
  - `TOP_OCTAVE = 10`
  - the 12-entry `SEMI_INC` constant table
  - the `IDLE`/`CONV`/`APPLY` state encoding
- **Sub-module `note_to_inc`:**
  - contains the `CONV`/`APPLY` divider and table shift.
  - handshake in, `inc_target` plus a done pulse out.
  - the top level keeps the accumulator, gate and glide logic.

## Test plan
- **Note 69 on:** reset, then note-on 69 (`RETRIGGER` = 1). Expect:
  - `note_ready` low for 7 cycles.
  - `inc_cur` = 153791 and `gate` = 1.
  - after 109 ticks, `phase` = 1023; after 110 ticks, `acc` = 139794 and `phase` = 8 (wrap).
- **Note 127 on:** expect `note_ready` low for 12 cycles and `inc_cur` = `SEMI_INC[7]` unshifted. Note 0: low 2 cycles, `inc_cur` = `SEMI_INC[0] >> 10`.
- **Note-off matching:** with 69 gated, note-off 70 leaves `gate` = 1. Note-off 69 gives `gate` = 0 next edge, `note_ready` stays 1, and `phase` keeps advancing at 153791 per tick.
- **Reset mid-operation:** assert `reset` during `CONV` of note 100. Expect all outputs at reset values and `note_ready` = 1. After release, note-on 69 completes normally.
- **Tick collision:** `sample_tick` on the `APPLY` edge, `RETRIGGER` = 1 → `acc` = 0. With `RETRIGGER` = 0, the accumulate uses the old increment.
- **Glide (`PHASE_GENERATOR_GLIDE_EN`, `GLIDE_SHIFT` = 6):** 69 then 81. Expect the first tick after `APPLY` to give `inc_cur` = 156193, and `inc_cur` to converge exactly to 307582.
